// File: rtl/serial_loopback_shifter.sv
// Parallel-to-serial-to-parallel loopback: a load/shift source register feeds a
// capture register one bit every second cycle, MSB first.
module serial_loopback_shifter #(
  parameter int unsigned M = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] bus_in,
  output logic         active,
  output logic         shift,
  output logic         bit_out,
  output logic [M-1:0] byte_out,
  output logic         done
);

  localparam int unsigned CW = $clog2(M + 1);

  logic [M-1:0]  src_q;
  logic [M-1:0]  src_d;
  logic [M-1:0]  cap_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          active_d;
  logic          done_d;

  // Shift strobe and serial bit come straight from flops, never from inputs.
  assign shift   = active & tick_q;
  assign bit_out = src_q[M-1];

  // Next-state: start has priority over a shift on the same edge.
  always_comb begin
    src_d    = src_q;
    cap_d    = byte_out;
    cnt_d    = cnt_q;
    active_d = active;
    done_d   = 1'b0;
    if (start) begin
      src_d    = bus_in;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (shift) begin
      src_d = {src_q[M-2:0], 1'b0};
      cap_d = {byte_out[M-2:0], src_q[M-1]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(M - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // State registers; the divide-by-2 tick free-runs out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q    <= '0;
      byte_out <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      src_q    <= src_d;
      byte_out <= cap_d;
      cnt_q    <= cnt_d;
      tick_q   <= ~tick_q;
      active   <= active_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_loopback_shifter.sv
// Directed bench for serial_loopback_shifter (M=5): reset, transfers in both
// tick phases, back-to-back, abort by reset and restart mid-transfer.
module tb_serial_loopback_shifter;

  localparam int unsigned M = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [M-1:0] bus_in;
  logic         active;
  logic         shift;
  logic         bit_out;
  logic [M-1:0] byte_out;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  logic mtick = 1'b0;

  serial_loopback_shifter #(.M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .bus_in(bus_in),
    .active(active), .shift(shift), .bit_out(bit_out),
    .byte_out(byte_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge. mtick models the divider.
  task automatic step();
    @(posedge clk);
    mtick = reset ? ~mtick : 1'b0;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".active"}, 32'(active), 0);
    check({tag, ".shift"}, 32'(shift), 0);
    check({tag, ".bit_out"}, 32'(bit_out), 0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  // Pulse start with word when the pre-edge tick equals phase; follow to done.
  task automatic run_xfer(input string tag, input logic [M-1:0] word, input logic phase);
    int cyc, nsh, last_sh, done_cyc, exp_first;
    logic [M-1:0] w;
    w = word;
    for (int i = 0; i < 2 && mtick != phase; i++) step();
    check({tag, ".phase"}, 32'(mtick), 32'(phase));
    exp_first = (mtick == 1'b0) ? 1 : 2;
    bus_in = word;
    start  = 1'b1;
    step();
    start  = 1'b0;
    bus_in = '0;
    check({tag, ".active_after_start"}, 32'(active), 1);
    nsh = 0; last_sh = 0; done_cyc = -1; cyc = 0;
    while (cyc < 30 && done_cyc < 0) begin
      if (shift) begin
        if (nsh == 0) check({tag, ".first_shift_delay"}, 32'(cyc + 1), 32'(exp_first));
        else check({tag, ".shift_spacing"}, 32'(cyc + 1 - last_sh), 2);
        if (nsh < M) check({tag, ".bit_out"}, 32'(bit_out), 32'(w[M-1-nsh]));
        last_sh = cyc + 1;
        nsh++;
      end
      step();
      cyc++;
      if (done) done_cyc = cyc;
    end
    check({tag, ".done_seen"}, 32'(done_cyc >= 0), 1);
    check({tag, ".done_latency"}, 32'(done_cyc), 32'(exp_first == 1 ? 2*M-1 : 2*M));
    check({tag, ".nshifts"}, 32'(nsh), 32'(M));
    check({tag, ".byte_out"}, 32'(byte_out), 32'(word));
    check({tag, ".active_end"}, 32'(active), 0);
    check({tag, ".bit_out_end"}, 32'(bit_out), 0);
    step();
    check({tag, ".done_width"}, 32'(done), 0);
    check({tag, ".byte_hold"}, 32'(byte_out), 32'(word));
  endtask

  // Start a transfer and let n shifts happen; done must stay low meanwhile.
  task automatic partial_xfer(input string tag, input logic [M-1:0] word, input int n);
    int nsh, cyc;
    bus_in = word;
    start  = 1'b1;
    step();
    start  = 1'b0;
    nsh = 0; cyc = 0;
    while (cyc < 20 && nsh < n) begin
      if (shift) nsh++;
      step();
      cyc++;
      if (done) check({tag, ".early_done"}, 32'(done), 0);
    end
    check({tag, ".shifts_reached"}, 32'(nsh), 32'(n));
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b1;
    bus_in = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("rst%0d", i));
      check($sformatf("rst%0d.byte_out", i), 32'(byte_out), 0);
    end
    start  = 1'b0;
    bus_in = '0;
    reset  = 1'b1;
    step();
    check_idle("released");

    run_xfer("x11_p0", 5'h11, 1'b0);
    run_xfer("x11_p1", 5'h11, 1'b1);
    run_xfer("b2b_0A", 5'h0A, 1'b0);
    run_xfer("b2b_15", 5'h15, 1'b1);

    // Abort by reset after two shifts: no done, everything cleared.
    partial_xfer("abort", 5'h1F, 2);
    reset = 1'b0;
    step();
    check_idle("abort_rst");
    check("abort_rst.byte_out", 32'(byte_out), 0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_idle($sformatf("abort_post%0d", i));
    end
    run_xfer("after_abort_03", 5'h03, 1'b1);

    // Restart mid-transfer: counter clears and five fresh shifts follow.
    partial_xfer("restart_1F", 5'h1F, 3);
    run_xfer("restart_05", 5'h05, mtick);
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
      check($sformatf("idle%0d.byte_out", i), 32'(byte_out), 32'h05);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
